matchstick_game_ctrl: RTL and testbench
=======================================

// Module: matchstick_game_ctrl
// PURPOSE
// - Parametrised matchstick-game controller, successor to the fixed 2-player/100-stick FPGA game.
// - Debounces the start and move buttons, validates each move and removes the sticks taken.
// - Rotates the turn across NUM_PLAYERS players and reports the winner.
// - Feeds the seven-segment/LED display logic through sticks_left, cur_player and the status flags.
// PARAMETERS
// - NUM_PLAYERS   2    players, 2..8; turn order 0,1,..,NUM_PLAYERS-1,0,..
// - INIT_STICKS   100  pile size at start; must be < 2**STICK_W
// - STICK_W       8    width of the pile counter
// - TAKE_W        4    width of take_in
// - MIN_TAKE      1    smallest legal take
// - MAX_TAKE      10   largest legal take; must be >= MIN_TAKE
// - DEBOUNCE_CYC  64   consecutive high samples that count as a press
// PORTS
// - clk         in   1        system clock
// - rst_n       in   1        asynchronous active-low reset
// - start_btn   in   1        raw start/restart pushbutton, active-high
// - move_btn    in   1        raw "commit move" pushbutton, active-high
// - take_in     in   TAKE_W   sticks requested (switches), sampled on accepted press
// - sticks_left out  STICK_W  current pile
// - cur_player  out  PW       player to move, PW=$clog2(NUM_PLAYERS)
// - illegal     out  1        last attempted move was rejected
// - game_over   out  1        pile reached 0
// - winner      out  PW       valid while game_over=1
// - move_count  out  8        legal moves this game; saturates at 255
// BEHAVIOUR
// - Reset (async assert, sync deassert use):
//   - state=IDLE, sticks_left=INIT_STICKS, cur_player=0.
//   - illegal=0, game_over=0, winner=0, move_count=0, debouncer counters cleared.
// - Debounce: a button counts as pressed after DEBOUNCE_CYC consecutive high samples.
//   - Exactly one 1-cycle pulse per press.
//   - The button must go low before it can pulse again.
// - States (matchstick_pkg::state_t): IDLE, PLAY, EVAL, OVER.
// - start_pulse, any state (including EVAL and OVER):
//   - Next cycle: state=PLAY, sticks_left=INIT_STICKS, cur_player=0.
//   - Also clears illegal, game_over, winner and move_count.
//   - If start_pulse and move_pulse occur in the same cycle, start wins and the move is dropped.
// - PLAY + move_pulse: latch take_in into take_q, state=EVAL.
//   - take_in is ignored at all other times.
// - EVAL (one cycle): legal iff MIN_TAKE <= take_q <= MAX_TAKE and take_q <= sticks_left.
//   - Compare at STICK_W+1 bits so the result never underflows.
//   - Illegal: illegal=1; pile, player and move_count unchanged; back to PLAY.
//   - Legal: sticks_left -= take_q, illegal=0, move_count++ (saturating).
//     - If the new pile is non-zero: cur_player advances modulo NUM_PLAYERS, back to PLAY.
//     - If the new pile is 0: game_over=1, winner set per CONFIGURATION, state=OVER.
//       cur_player is not advanced.
// - Latency: a move press reaches the outputs 2 cycles after move_pulse.
// - OVER: outputs hold and move_pulse is ignored; only start_pulse leaves OVER.
// - IDLE: only start_pulse has an effect.
// CONFIGURATION
// - MATCHSTICK_MISERE_EN undefined (normal play): the player who takes the last stick wins.
//   - winner = cur_player.
// - MATCHSTICK_MISERE_EN defined (misere play): the player who takes the last stick loses.
//   - winner = (cur_player+1) mod NUM_PLAYERS.
//   - A legal take that would empty the pile while taking fewer than all remaining is impossible,
//     so no extra rule is needed.
// STRUCTURE
// - Package matchstick_pkg:
//   - state_t enum (IDLE=2'd0, PLAY=2'd1, EVAL=2'd2, OVER=2'd3).
//   - MOVE_CNT_W=8.
//   - Function next_player(p, n).
// - Sub-module btn_debounce #(DEBOUNCE_CYC): clk, rst_n, btn_raw -> btn_pulse.
//   - 2-flop synchroniser, run counter, press-edge pulse.
//   - Instantiated twice (start, move).
// - Top level: FSM, pile arithmetic, turn counter, winner logic.
// TESTING
// - Use DEBOUNCE_CYC=4 in sim unless a test says otherwise.
// - Reset then start: sticks_left=100, cur_player=0, game_over=0, illegal=0.
// - take_in=7 + move: sticks_left=93, cur_player=1, move_count=1, illegal=0 two cycles after move_pulse.
// - take_in=0, then 11, then 15: each sets illegal=1, pile stays 93, cur_player stays 1.
// - Pile 3, take_in=5: illegal=1.
//   - take_in=3: game_over=1, sticks_left=0.
//   - Normal: winner=player that moved; misere build: next player.
//   - Further move presses ignored.
// - NUM_PLAYERS=3:
//   - Turn order 0,1,2,0 across four legal moves.
//   - Start pressed mid-EVAL: pile=INIT_STICKS, player 0, move_count=0.
// - Bounce: move_btn toggling with high runs shorter than DEBOUNCE_CYC produces no move.
//   - A held button produces exactly one move.
//   - rst_n low mid-game restores all reset values immediately.

Source files
------------

// File: rtl/matchstick_pkg.sv
// Shared types and helpers for the matchstick game controller.
package matchstick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        EVAL = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int MOVE_CNT_W = 8;

    // Turn rotation: 0,1,..,n-1,0,..
    function automatic int next_player(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, run-length counter, one pulse per press.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] run_q;
    logic          pulse_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            run_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            // The counter parks at DEBOUNCE_CYC until the button drops, which blocks re-pulsing.
            if (!sync2_q) begin
                run_q <= '0;
            end else if (run_q != CW'(DEBOUNCE_CYC)) begin
                run_q   <= run_q + 1'b1;
                pulse_q <= (run_q == CW'(DEBOUNCE_CYC - 1));
            end
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/matchstick_game_ctrl.sv
// Matchstick game controller: debounced buttons, move validation, turn rotation, winner.
// Define MATCHSTICK_MISERE_EN for misere play (the player taking the last stick loses).
module matchstick_game_ctrl
    import matchstick_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int INIT_STICKS  = 100,
    parameter int STICK_W      = 8,
    parameter int TAKE_W       = 4,
    parameter int MIN_TAKE     = 1,
    parameter int MAX_TAKE     = 10,
    parameter int DEBOUNCE_CYC = 64,
    localparam int PW          = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_btn,
    input  logic                  move_btn,
    input  logic [TAKE_W-1:0]     take_in,
    output logic [STICK_W-1:0]    sticks_left,
    output logic [PW-1:0]         cur_player,
    output logic                  illegal,
    output logic                  game_over,
    output logic [PW-1:0]         winner,
    output logic [MOVE_CNT_W-1:0] move_count
);

    logic start_pulse;
    logic move_pulse;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_start_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (start_btn),
        .btn_pulse (start_pulse)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_move_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (move_btn),
        .btn_pulse (move_pulse)
    );

    state_t                  state_q;
    logic [STICK_W-1:0]      sticks_q;
    logic [PW-1:0]           player_q;
    logic                    illegal_q;
    logic                    over_q;
    logic [PW-1:0]           winner_q;
    logic [MOVE_CNT_W-1:0]   count_q;
    logic [TAKE_W-1:0]       take_q;

    // One extra bit keeps the pile comparison and subtraction free of wrap-around.
    logic [STICK_W:0]        take_ext;
    logic [STICK_W:0]        pile_diff;
    logic [STICK_W-1:0]      pile_rem;
    logic                    move_legal;
    logic [PW-1:0]           player_adv;

    assign take_ext   = (STICK_W + 1)'(take_q);
    assign pile_diff  = {1'b0, sticks_q} - take_ext;
    assign pile_rem   = pile_diff[STICK_W-1:0];
    assign move_legal = (take_ext >= (STICK_W + 1)'(MIN_TAKE)) &&
                        (take_ext <= (STICK_W + 1)'(MAX_TAKE)) &&
                        (take_ext <= {1'b0, sticks_q});
    assign player_adv = PW'(next_player(int'(player_q), NUM_PLAYERS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sticks_q  <= STICK_W'(INIT_STICKS);
            player_q  <= '0;
            illegal_q <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= '0;
            count_q   <= '0;
            take_q    <= '0;
        end else if (start_pulse) begin
            // Start overrides everything, including a move pulse in the same cycle.
            state_q   <= PLAY;
            sticks_q  <= STICK_W'(INIT_STICKS);
            player_q  <= '0;
            illegal_q <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= '0;
            count_q   <= '0;
        end else begin
            case (state_q)
                PLAY: begin
                    if (move_pulse) begin
                        take_q  <= take_in;
                        state_q <= EVAL;
                    end
                end
                EVAL: begin
                    if (!move_legal) begin
                        illegal_q <= 1'b1;
                        state_q   <= PLAY;
                    end else begin
                        sticks_q  <= pile_rem;
                        illegal_q <= 1'b0;
                        if (count_q != '1) begin
                            count_q <= count_q + 1'b1;
                        end
                        if (pile_rem != '0) begin
                            player_q <= player_adv;
                            state_q  <= PLAY;
                        end else begin
                            over_q   <= 1'b1;
`ifdef MATCHSTICK_MISERE_EN
                            winner_q <= player_adv;
`else
                            winner_q <= player_q;
`endif
                            state_q  <= OVER;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sticks_left = sticks_q;
    assign cur_player  = player_q;
    assign illegal     = illegal_q;
    assign game_over   = over_q;
    assign winner      = winner_q;
    assign move_count  = count_q;

endmodule

// File: tb/tb_matchstick_game_ctrl.sv
// Scoreboard bench for matchstick_game_ctrl: a 2-player and a 3-player instance, DEBOUNCE_CYC=4.
module tb_matchstick_game_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

`ifdef MATCHSTICK_MISERE_EN
    localparam int WIN_EXP = 0;
`else
    localparam int WIN_EXP = 1;
`endif

    logic       st2 = 1'b0, mv2 = 1'b0, st3 = 1'b0, mv3 = 1'b0;
    logic [3:0] take2 = '0, take3 = '0;
    logic [7:0] pile2, pile3, cnt2, cnt3;
    logic       p2, w2;
    logic [1:0] p3, w3;
    logic       ill2, ill3, over2, over3;

    matchstick_game_ctrl #(.NUM_PLAYERS(2), .DEBOUNCE_CYC(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_btn(st2), .move_btn(mv2), .take_in(take2),
        .sticks_left(pile2), .cur_player(p2), .illegal(ill2), .game_over(over2),
        .winner(w2), .move_count(cnt2)
    );

    matchstick_game_ctrl #(.NUM_PLAYERS(3), .DEBOUNCE_CYC(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_btn(st3), .move_btn(mv3), .take_in(take3),
        .sticks_left(pile3), .cur_player(p3), .illegal(ill3), .game_over(over3),
        .winner(w3), .move_count(cnt3)
    );

    typedef struct {
        int    id;
        string name;
        int    pile, player, ill, over, win, cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic obs_req = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Monitor: pops one expectation per observation strobe and compares the selected DUT.
    always @(negedge clk) begin
        if (obs_req) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.id == 2) begin
                    check({mon_e.name, ".pile"},   int'(pile2), mon_e.pile);
                    check({mon_e.name, ".player"}, int'(p2),    mon_e.player);
                    check({mon_e.name, ".illegal"},int'(ill2),  mon_e.ill);
                    check({mon_e.name, ".over"},   int'(over2), mon_e.over);
                    check({mon_e.name, ".winner"}, int'(w2),    mon_e.win);
                    check({mon_e.name, ".count"},  int'(cnt2),  mon_e.cnt);
                end else begin
                    check({mon_e.name, ".pile"},   int'(pile3), mon_e.pile);
                    check({mon_e.name, ".player"}, int'(p3),    mon_e.player);
                    check({mon_e.name, ".illegal"},int'(ill3),  mon_e.ill);
                    check({mon_e.name, ".over"},   int'(over3), mon_e.over);
                    check({mon_e.name, ".winner"}, int'(w3),    mon_e.win);
                    check({mon_e.name, ".count"},  int'(cnt3),  mon_e.cnt);
                end
            end
        end
    end

    task automatic observe(input int id, input string name, input int pile, input int player,
                           input int ill, input int over, input int win, input int cnt);
        exp_t e;
        e.id = id; e.name = name; e.pile = pile; e.player = player;
        e.ill = ill; e.over = over; e.win = win; e.cnt = cnt;
        sb.push_back(e);
        obs_req = 1'b1;
        @(negedge clk);
        #1 obs_req = 1'b0;
    endtask

    task automatic press_move(input int id, input int take, input int hold);
        @(posedge clk); #1;
        if (id == 2) begin take2 = 4'(take); mv2 = 1'b1; end
        else         begin take3 = 4'(take); mv3 = 1'b1; end
        repeat (hold) @(posedge clk);
        #1 mv2 = 1'b0; mv3 = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic press_start(input int id);
        @(posedge clk); #1;
        if (id == 2) st2 = 1'b1; else st3 = 1'b1;
        repeat (10) @(posedge clk);
        #1 st2 = 1'b0; st3 = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // Hand-computed 2-player game: pile, player, illegal, move_count after each press.
    int take_v [17] = '{7, 0, 11, 15, 7, 10, 10, 10, 10, 10, 10, 10, 10, 3, 5, 3, 1};
    int pile_v [17] = '{93, 93, 93, 93, 86, 76, 66, 56, 46, 36, 26, 16, 6, 3, 3, 0, 0};
    int ply_v  [17] = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
    int ill_v  [17] = '{0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int cnt_v  [17] = '{1, 1, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 11, 12, 12};
    int over_v [17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        observe(2, "reset2", 100, 0, 0, 0, 0, 0);
        observe(3, "reset3", 100, 0, 0, 0, 0, 0);

        press_move(2, 5, 10);
        observe(2, "idle_move", 100, 0, 0, 0, 0, 0);

        // 3-player turn rotation, then start landing in EVAL.
        press_start(3);
        observe(3, "start3", 100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            press_move(3, 1, 10);
            observe(3, $sformatf("rot%0d", i), 99 - i, (i + 1) % 3, 0, 0, 0, i + 1);
        end
        @(posedge clk); #1 take3 = 4'd2; mv3 = 1'b1;
        @(posedge clk); #1 st3 = 1'b1;
        repeat (10) @(posedge clk);
        #1 mv3 = 1'b0; st3 = 1'b0;
        repeat (4) @(posedge clk);
        observe(3, "start_in_eval", 100, 0, 0, 0, 0, 0);

        // Full 2-player game down to an empty pile.
        press_start(2);
        observe(2, "start2", 100, 0, 0, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            press_move(2, take_v[i], 10);
            observe(2, $sformatf("game%0d", i), pile_v[i], ply_v[i], ill_v[i], over_v[i],
                    over_v[i] ? WIN_EXP : 0, cnt_v[i]);
        end

        // Start and move pressed together from OVER: start wins, move dropped.
        @(posedge clk); #1 take2 = 4'd5; mv2 = 1'b1; st2 = 1'b1;
        repeat (10) @(posedge clk);
        #1 mv2 = 1'b0; st2 = 1'b0;
        repeat (4) @(posedge clk);
        observe(2, "start_and_move", 100, 0, 0, 0, 0, 0);

        press_move(2, 10, 30);
        observe(2, "held_once", 90, 1, 0, 0, 0, 1);

        take2 = 4'd10;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 mv2 = 1'b1;
            repeat (3) @(posedge clk);
            #1 mv2 = 1'b0;
        end
        repeat (8) @(posedge clk);
        observe(2, "bounce", 90, 1, 0, 0, 0, 1);

        // Asynchronous reset mid-game, observed before the next rising edge.
        @(posedge clk); #1 rst_n = 1'b0;
        observe(2, "async_reset", 100, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        check("sb_leftover", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
